// File: rtl/npc_pkg.sv
// Shared NPC core definitions: fetch FSM encoding, bus response codes and reset PC.
package npc_pkg;

   typedef enum logic [1:0] {
      StReq  = 2'd0,
      StWait = 2'd1,
      StHold = 2'd2,
      StIdle = 2'd3
   } fetch_state_e;

   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;

   function automatic logic word_aligned(input logic [1:0] addr_lo);
      return addr_lo == 2'b00;
   endfunction

endpackage

// File: rtl/inst_fetch_stage.sv
// Multi-cycle instruction fetch: PC -> memory read request -> response -> IDU handshake.
module inst_fetch_stage
   import npc_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = NPC_RESET_PC,
   parameter logic [31:0] FETCH_COUNT_RST = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   output logic        pc_ready,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] fetch_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  araddr_q, araddr_d;
   logic [31:0]  inst_q, inst_d;
   logic         inst_err_q, inst_err_d;
   logic [31:0]  fetch_count_q, fetch_count_d;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      araddr_d      = araddr_q;
      inst_d        = inst_q;
      inst_err_d    = inst_err_q;
      fetch_count_d = fetch_count_q;
      arvalid       = 1'b0;
      rready        = 1'b0;
      inst_valid    = 1'b0;
      pc_ready      = 1'b0;

      case (state_q)
         StReq: begin
            arvalid = 1'b1;
            if (arready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            rready = 1'b1;
            if (rvalid) begin
               inst_d     = rdata;
               inst_err_d = (rresp != RESP_OKAY);
               state_d    = StHold;
            end
         end
         StHold: begin
            inst_valid = 1'b1;
            if (inst_ready) begin
               fetch_count_d = fetch_count_q + 32'd1;
               state_d       = StIdle;
            end
         end
         StIdle: begin
            pc_ready = 1'b1;
            if (pc_valid) begin
               pc_d     = pc_in;
               araddr_d = {pc_in[31:2], 2'b00};
               if (word_aligned(pc_in[1:0])) begin
                  state_d = StReq;
               end else begin
                  // Misaligned PC faults locally; the bus never sees it.
                  inst_d     = 32'd0;
                  inst_err_d = 1'b1;
                  state_d    = StHold;
               end
            end
         end
         default: begin
            state_d = StReq;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StReq;
         pc_q          <= RESET_PC;
         araddr_q      <= {RESET_PC[31:2], 2'b00};
         inst_q        <= 32'd0;
         inst_err_q    <= 1'b0;
         fetch_count_q <= FETCH_COUNT_RST;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         araddr_q      <= araddr_d;
         inst_q        <= inst_d;
         inst_err_q    <= inst_err_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign araddr      = araddr_q;
   assign inst        = inst_q;
   assign inst_pc     = pc_q;
   assign inst_err    = inst_err_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Randomised bench for inst_fetch_stage against a transaction-level fetch model.
module tb_inst_fetch_stage;
   import npc_pkg::*;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] fetch_count;

   logic        w_pc_ready, w_arvalid, w_rready, w_inst_err, w_inst_valid;
   logic [31:0] w_araddr, w_inst, w_inst_pc, w_fetch_count;

   inst_fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
      .rvalid(rvalid), .rready(rready), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .fetch_count(fetch_count)
   );

   // Counter preloaded two short of wrap; all handshakes tied high.
   inst_fetch_stage #(.RESET_PC(RST_PC), .FETCH_COUNT_RST(32'hFFFF_FFFE)) u_wrap (
      .clk(clk), .rst(rst), .pc_in(RST_PC), .pc_valid(1'b1), .pc_ready(w_pc_ready),
      .araddr(w_araddr), .arvalid(w_arvalid), .arready(1'b1), .rdata(32'd0), .rresp(2'b00),
      .rvalid(1'b1), .rready(w_rready), .inst(w_inst), .inst_pc(w_inst_pc),
      .inst_err(w_inst_err), .inst_valid(w_inst_valid), .inst_ready(1'b1),
      .fetch_count(w_fetch_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: current fetch PC, its expected result and bus traffic seen for it.
   logic [31:0] cur_pc, exp_inst, cnt;
   logic        exp_err, have_res, prev_held;
   int          ar_n, r_n;

   // Stimulus knobs.
   int          ar_p, r_p, ir_p, pv_p;
   bit          ovr_pc_en, frc_en;
   logic [31:0] ovr_pc, frc_data;
   logic [1:0]  frc_resp;

   function automatic bit pct(input int p);
      return int'($urandom_range(99)) < p;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      p = RST_PC + ($urandom_range(255) << 2);
      if ($urandom_range(3) == 0) p[1:0] = 2'($urandom_range(1, 3));
      return p;
   endfunction

   function automatic bit is_aligned(input logic [31:0] p);
      return p[1:0] == 2'b00;
   endfunction

   task automatic model_reset();
      cur_pc    = RST_PC;
      have_res  = 1'b0;
      exp_inst  = 32'd0;
      exp_err   = 1'b0;
      ar_n      = 0;
      r_n       = 0;
      cnt       = 32'd0;
      prev_held = 1'b0;
   endtask

   // Called at a negedge: choose inputs, check outputs, update model, advance a cycle.
   task automatic cycle();
      bit hs_pc, hs_ar, hs_r, hs_inst;
      pc_valid   = pct(pv_p);
      pc_in      = ovr_pc_en ? ovr_pc : rand_pc();
      arready    = pct(ar_p);
      rvalid     = pct(r_p);
      inst_ready = pct(ir_p);
      if (rready && rvalid) begin
         rdata = frc_en ? frc_data : mem_word(cur_pc);
         rresp = frc_en ? frc_resp : (pct(20) ? 2'($urandom_range(1, 3)) : RESP_OKAY);
      end else begin
         rdata = $urandom;
         rresp = 2'($urandom_range(0, 3));
      end

      chk("onehot", 32'(arvalid) + 32'(rready) + 32'(inst_valid) + 32'(pc_ready), 32'd1);
      chk("fetch_count", fetch_count, cnt);
      chk("araddr_lo", {30'd0, araddr[1:0]}, 32'd0);
      if (arvalid) chk("araddr", araddr, {cur_pc[31:2], 2'b00});
      if (!is_aligned(cur_pc)) chk("no_bus_misaligned", {30'd0, arvalid, rready}, 32'd0);
      if (prev_held) chk("valid_held", 32'(inst_valid), 32'd1);
      if (inst_valid) begin
         chk("result_ready", 32'(have_res), 32'd1);
         chk("inst", inst, exp_inst);
         chk("inst_pc", inst_pc, cur_pc);
         chk("inst_err", 32'(inst_err), 32'(exp_err));
      end

      hs_pc   = pc_ready && pc_valid;
      hs_ar   = arvalid && arready;
      hs_r    = rready && rvalid;
      hs_inst = inst_valid && inst_ready;
      if (hs_ar) ar_n++;
      if (hs_r) begin
         r_n++;
         have_res = 1'b1;
         exp_inst = rdata;
         exp_err  = (rresp != RESP_OKAY);
      end
      if (hs_inst) begin
         cnt++;
         chk("ar_per_fetch", ar_n, is_aligned(cur_pc) ? 1 : 0);
         chk("r_per_fetch", r_n, is_aligned(cur_pc) ? 1 : 0);
         have_res = 1'b0;
      end
      if (hs_pc) begin
         cur_pc = pc_in;
         ar_n   = 0;
         r_n    = 0;
         if (!is_aligned(pc_in)) begin
            have_res = 1'b1;
            exp_inst = 32'd0;
            exp_err  = 1'b1;
         end
      end
      prev_held = inst_valid && !inst_ready;
      @(negedge clk);
   endtask

   function automatic bit sel(input int which);
      case (which)
         0:       return arvalid;
         1:       return rready;
         2:       return inst_valid;
         default: return pc_ready;
      endcase
   endfunction

   task automatic run_until(input int which, input int budget);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (sel(which)) begin
            hit = 1'b1;
            break;
         end
         cycle();
      end
      if (!hit) hit = sel(which);
      chk("wait_timeout", 32'(hit), 32'd1);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      pc_valid   = 1'b0;
      arready    = 1'b0;
      rvalid     = 1'b0;
      inst_ready = 1'b0;
      rdata      = 32'd0;
      rresp      = 2'b00;
      pc_in      = 32'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   logic [31:0] snap_inst, snap_pc, exp_c;

   initial begin
      rst = 1'b1;
      ar_p = 100; r_p = 100; ir_p = 100; pv_p = 100;
      ovr_pc_en = 1'b1; ovr_pc = RST_PC;
      frc_en = 1'b1; frc_resp = 2'b00; frc_data = 32'h0000_0413;
      do_reset();

      // Zero-wait memory: reset values and minimum latency.
      chk("rst_arvalid", 32'(arvalid), 32'd1);
      chk("rst_araddr", araddr, RST_PC);
      chk("rst_inst_pc", inst_pc, RST_PC);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_pc_ready", 32'(pc_ready), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_err", 32'(inst_err), 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      cycle();
      chk("c2_rready", 32'(rready), 32'd1);
      cycle();
      chk("c3_inst_valid", 32'(inst_valid), 32'd1);
      chk("c3_inst", inst, 32'h0000_0413);
      chk("c3_inst_pc", inst_pc, RST_PC);
      chk("c3_inst_err", 32'(inst_err), 32'd0);
      cycle();
      chk("c4_count", fetch_count, 32'd1);
      chk("c4_pc_ready", 32'(pc_ready), 32'd1);
      chk("wrap_pre", w_fetch_count, 32'hFFFF_FFFF);
      cycle(); cycle(); cycle();
      chk("c7_inst_valid", 32'(inst_valid), 32'd1);
      cycle();
      chk("c8_count", fetch_count, 32'd2);
      chk("wrap_zero", w_fetch_count, 32'd0);

      // Slow memory: arready after 3 cycles, rvalid after 5.
      ar_p = 0; frc_data = 32'h1234_ABCD;
      cycle();
      run_until(0, 4);
      for (int i = 0; i < 3; i++) begin
         chk("ar_hold_valid", 32'(arvalid), 32'd1);
         chk("ar_hold_addr", araddr, RST_PC);
         cycle();
      end
      ar_p = 100; r_p = 0;
      cycle();
      for (int i = 0; i < 5; i++) begin
         chk("r_wait", 32'(rready), 32'd1);
         cycle();
      end
      r_p = 100; ir_p = 0;
      cycle();
      chk("dly_inst_valid", 32'(inst_valid), 32'd1);
      chk("dly_inst", inst, 32'h1234_ABCD);

      // IDU back-pressure for 10 cycles.
      snap_inst = 32'h1234_ABCD;
      snap_pc   = RST_PC;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 32'(inst_valid), 32'd1);
         chk("bp_inst", inst, snap_inst);
         chk("bp_inst_pc", inst_pc, snap_pc);
         chk("bp_pc_ready", 32'(pc_ready), 32'd0);
         cycle();
      end
      ir_p = 100;
      cycle();

      // Misaligned PC: fault without a bus request.
      ovr_pc = 32'h8000_0006;
      cycle();
      chk("mis_arvalid", 32'(arvalid), 32'd0);
      chk("mis_valid", 32'(inst_valid), 32'd1);
      chk("mis_err", 32'(inst_err), 32'd1);
      chk("mis_inst", inst, 32'd0);
      chk("mis_pc", inst_pc, 32'h8000_0006);
      ovr_pc = RST_PC;
      cycle();

      // Error response still delivers data and counts.
      frc_resp = 2'b10; frc_data = 32'hDEAD_BEEF;
      run_until(2, 10);
      chk("eresp_err", 32'(inst_err), 32'd1);
      chk("eresp_inst", inst, 32'hDEAD_BEEF);
      exp_c = cnt + 32'd1;
      cycle();
      chk("eresp_count", fetch_count, exp_c);

      // Reset pulse while waiting on the response.
      frc_resp = 2'b00;
      run_until(1, 10);
      rst    = 1'b1;
      rvalid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("midrst_arvalid", 32'(arvalid), 32'd1);
      chk("midrst_araddr", araddr, RST_PC);
      chk("midrst_count", fetch_count, 32'd0);

      // Random traffic.
      frc_en = 1'b0; ovr_pc_en = 1'b0;
      for (int seg = 0; seg < 10; seg++) begin
         ar_p = int'($urandom_range(20, 100));
         r_p  = int'($urandom_range(20, 100));
         ir_p = int'($urandom_range(20, 100));
         pv_p = int'($urandom_range(20, 100));
         repeat (300) cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_fetch_stage.md
# inst_fetch_stage

Multi-cycle instruction fetch stage for the NPC core. Issues a read request for the current PC to instruction memory over a valid/ready read channel, captures the returned word, and presents the instruction to the decode stage (IDU) under a valid/ready handshake. It then waits for the next PC from the writeback/next-PC logic. This replaces single-cycle combinational fetch, so memory latency can be arbitrary.

## Interface
Parameters:
- `RESET_PC`, `32'h8000_0000`: first PC fetched after reset.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_in`  in  32  next PC from next-PC logic.
- `pc_valid`  in  1  `pc_in` valid.
- `pc_ready`  out  1  stage accepts a new PC.
- `araddr`  out  32  memory read address, registered.
- `arvalid`  out  1  read request valid.
- `arready`  in  1  memory accepts request.
- `rdata`  in  32  read data.
- `rresp`  in  2  response; `2'b00` = OK, else error.
- `rvalid`  in  1  read response valid.
- `rready`  out  1  stage accepts response.
- `inst`  out  32  fetched instruction to IDU.
- `inst_pc`  out  32  PC of `inst`.
- `inst_err`  out  1  fetch fault: misaligned PC or `rresp != 0`.
- `inst_valid`  out  1  `inst`/`inst_pc`/`inst_err` valid.
- `inst_ready`  in  1  IDU consumes instruction.
- `fetch_count`  out  32  number of completed `inst` handshakes.

## Operation
- FSM states: `REQ`, `WAIT`, `HOLD`, `IDLE`.
- `REQ`: `arvalid=1`, `araddr=pc`. On `arready`, go to `WAIT`.
- `WAIT`: `rready=1`. On `rvalid`, latch `inst<=rdata` and `inst_err<=(rresp!=0)`, then go to `HOLD`.
- `HOLD`: `inst_valid=1`. On `inst_ready`, increment `fetch_count` (wraps `FFFF_FFFF→0`) and go to `IDLE`.
- `IDLE`: `pc_ready=1`. On `pc_valid`, latch `pc<=pc_in`, `inst_pc<=pc_in`.
  - If `pc_in[1:0]==0`, go to `REQ`.
  - Otherwise set `inst<=0`, `inst_err<=1`, go to `HOLD`. No bus request is issued.
- `arvalid`, `rready`, `inst_valid` and `pc_ready` are each high only in their own state. They are mutually exclusive, and exactly one is high every cycle.
- Outputs stay stable while in `HOLD` (AXI-style: no retraction of valid, no data change).
- An error fetch still completes the `inst` handshake and still counts in `fetch_count`.
- `araddr[1:0]` is always `2'b00` on the bus.

## Timing
- Reset values:
  - state=`REQ`, `pc=inst_pc=araddr=RESET_PC`
  - `arvalid=1` in the first cycle after reset
  - `rready=0`, `inst=0`, `inst_err=0`, `inst_valid=0`, `pc_ready=0`, `fetch_count=0`
- Minimum latency with `arready`, `rvalid` and `inst_ready` all tied high: `REQ` 1 cycle, `WAIT` 1 cycle, `HOLD` 1 cycle. The first `inst_valid` appears in the 3rd cycle after reset deassertion.
- A full loop with `pc_valid` high is 4 cycles per instruction.
- `rvalid` in the same cycle as `arready` is not sampled; the response is sampled only in `WAIT`.
- `inst` is updated only on the `WAIT→HOLD` transition.
- `rst` asserted in any state returns to reset values on the next edge. Any in-flight response is dropped. The memory model shares `rst`, so no stale response follows.
- Back-pressure: in `HOLD` with `inst_ready=0`, the stage stays indefinitely with all outputs held.

## Structure
- Shared package `npc_pkg`:
  - fetch FSM state enum (2-bit)
  - `RESP_OKAY = 2'b00`
  - `NPC_RESET_PC`, the default for `RESET_PC`
- Single module, no sub-modules. The FSM, PC/instruction registers and counter all live in `inst_fetch_stage`.

## Test plan
- Reset then zero-wait memory returning `32'h0000_0413` at `8000_0000`: `inst_valid` appears in the 3rd cycle with `inst=0000_0413`, `inst_pc=8000_0000`, `inst_err=0`; `fetch_count` becomes 1 after the handshake.
- `arready` delayed 3 cycles and `rvalid` delayed 5 cycles: `arvalid` and `araddr` are held stable throughout, and the single `inst` matches `rdata`.
- `inst_ready=0` for 10 cycles in `HOLD`: `inst`, `inst_pc` and `inst_valid` are unchanged, and `pc_ready=0`.
- `pc_in=8000_0006`: no `arvalid` is issued; the result is `inst_valid=1`, `inst_err=1`, `inst=0`, `inst_pc=8000_0006`.
- `rresp=2'b10` with `rdata=DEAD_BEEF`: `inst_err=1`, `inst=DEAD_BEEF`, and `fetch_count` still increments.
- `rst` pulsed during `WAIT`: the next cycle shows `arvalid=1`, `araddr=8000_0000`, `fetch_count=0`; a sequence of 2^32 handshakes, forced via a preload hook, shows wrap to 0.
